fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter HALT_INSN, default 32'h0000000C (syscall), meaning the instruction word that stops fetch.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port pc, output, width 32: the current fetch address, driven to the instruction memory.
REQ-006 The block SHALL have port instruction, input, width 32: the word returned combinationally by the instruction memory for pc.
REQ-007 The block SHALL have port stall, input, width 1: a downstream hazard request to hold PC and IF/ID.
REQ-008 The block SHALL have port redirect_valid, input, width 1: a taken branch, jump or jr.
REQ-009 The block SHALL have port redirect_pc, input, width 32: the redirect target address.
REQ-010 The block SHALL have port if_id_instr, output, width 32: the registered instruction passed to decode.
REQ-011 The block SHALL have port if_id_pc4, output, width 32: the registered PC+4 of if_id_instr.
REQ-012 The block SHALL have port if_id_valid, output, width 1: high when if_id_instr is a real, non-flushed instruction.
REQ-013 The block SHALL have port halted, output, width 1: high while the block is in state HALT.
REQ-014 The block SHALL have port fetch_count, output, width 32: the number of instructions delivered into IF/ID since reset.

Function
REQ-015 The block SHALL implement a two-state machine, RUN and HALT; halted SHALL equal (state == HALT).
REQ-016 In RUN, on each edge, the block SHALL apply exactly one action, chosen in priority order: redirect, then halt-entry, then stall, then advance.
REQ-017 On redirect (redirect_valid=1), the block SHALL set pc to {redirect_pc[31:2],2'b00}, set if_id_valid to 0 and if_id_instr to 32'h0, and leave fetch_count unchanged; redirect overrides a simultaneous stall.
REQ-018 Halt-entry SHALL occur when if_id_valid=1, if_id_instr=HALT_INSN and redirect_valid=0: state goes to HALT, pc is held, and if_id_valid is cleared.
REQ-019 Halt-entry SHALL NOT be gated by stall.
REQ-020 On stall with no redirect and no halt-entry, the block SHALL hold pc, if_id_instr, if_id_pc4, if_id_valid and fetch_count.
REQ-021 On advance, the block SHALL set pc to pc+4 (mod 2^32), if_id_instr to instruction, if_id_pc4 to pc+4, and if_id_valid to 1, and SHALL increment fetch_count.
REQ-022 Fetch latency SHALL be one cycle: the word at pc is visible on if_id_instr after the next rising edge.
REQ-023 PC wrap SHALL follow mod-2^32 arithmetic: 32'hFFFFFFFC advances to 32'h00000000; fetch_count SHALL wrap the same way.
REQ-024 In HALT, all registers SHALL be frozen, stall, redirect_valid and instruction SHALL be ignored, and only reset SHALL exit HALT.
REQ-025 pc SHALL be a direct register output with no combinational path from any input.

Reset
REQ-026 Asserting reset SHALL immediately, without waiting for clk, force pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_count=0 and state=RUN (halted=0).
REQ-027 Reset asserted mid-stall, mid-redirect or in HALT SHALL produce the same reset state; the first advance SHALL occur on the first rising edge after deassertion.

Structure
REQ-028 A shared package SHALL hold the state encoding (RUN, HALT), the NOP constant 32'h0 and the PC increment constant 4.
REQ-029 The IF/ID register SHALL be a sub-module named if_id_reg, with load, flush and hold controls; the PC register and the state machine SHALL reside in fetch_sequencer.

Verification
REQ-030 Straight-line: reset, then 3 edges with memory words A,B,C at 0,4,8 -> pc=0x0C, if_id_instr=C, if_id_pc4=0x0C, fetch_count=3.
REQ-031 Stall: at pc=0x08, hold stall for 2 edges -> pc stays 0x08, IF/ID unchanged, fetch_count unchanged; release -> pc=0x0C.
REQ-032 Redirect with stall: redirect_valid=1, redirect_pc=0x0000004E, stall=1 -> next pc=0x4C, if_id_valid=0, fetch_count unchanged.
REQ-033 Halt: 0x0000000C fetched at 0x10 -> one edge later in IF/ID, next edge halted=1, pc=0x14, if_id_valid=0; 5 further edges with redirect asserted -> no change.
REQ-034 Wrap and async reset: RESET_PC=0xFFFFFFFC, one advance -> pc=0x00000000; reset pulsed between edges -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// the NOP word and the PC step.
package fetch_sequencer_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if_id_reg.sv
// IF/ID pipeline register: flush clears the slot, load captures a fetched
// word, hold (or no request) keeps the current contents.
module if_id_reg
    import fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic        hold,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc4_out,
    output logic        valid_out
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush) begin
            // pc4 is left alone: it has no meaning while the slot is invalid.
            instr_d = NOP_INSN;
            valid_d = 1'b0;
        end else if (load && !hold) begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_INSN;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pc4_out   = pc4_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC register, RUN/HALT control and the IF/ID
// stage. One action per edge in RUN: redirect > halt-entry > stall > advance.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_RUN  | fetching; PC advances, stalls or is redirected each edge
//   ST_HALT | halt word reached decode; everything frozen until reset
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INSN = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  count_q, count_d;
    logic [31:0]  pc_plus4;
    logic         halt_hit;
    logic         ifid_load, ifid_flush, ifid_hold;

    assign pc_plus4 = pc_q + PC_INC;
    assign halt_hit = if_id_valid && (if_id_instr == HALT_INSN);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_hold  = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d       = align_word(redirect_pc);
                    ifid_flush = 1'b1;
                    ifid_hold  = 1'b0;
                end else if (halt_hit) begin
                    // Not gated by stall: the halt word is already in decode.
                    state_d    = ST_HALT;
                    ifid_flush = 1'b1;
                    ifid_hold  = 1'b0;
                end else if (!stall) begin
                    pc_d      = pc_plus4;
                    count_d   = count_q + 32'd1;
                    ifid_load = 1'b1;
                    ifid_hold = 1'b0;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_reg u_if_id (
        .clk       (clk),
        .reset     (reset),
        .load      (ifid_load),
        .flush     (ifid_flush),
        .hold      (ifid_hold),
        .instr_in  (instruction),
        .pc4_in    (pc_plus4),
        .instr_out (if_id_instr),
        .pc4_out   (if_id_pc4),
        .valid_out (if_id_valid)
    );

    assign pc          = pc_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected post-edge
// state, a monitor pops and compares after each edge or on an async check.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] pc0, ins0, ifi0, ifp0, cnt0;
    logic        ifv0, hlt0;
    logic [31:0] pc1, ins1, ifi1, ifp1, cnt1;
    logic        ifv1, hlt1;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h00: return 32'h1111_1111;
            32'h04: return 32'h2222_2222;
            32'h08: return 32'h3333_3333;
            32'h0C: return 32'h4444_4444;
            32'h10: return 32'h0000_000C;
            32'h4C: return 32'h5555_5555;
            default: return 32'h1000_0000 | a;
        endcase
    endfunction

    assign ins0 = imem(pc0);
    assign ins1 = imem(pc1);

    fetch_sequencer dut0 (
        .clk(clk), .reset(rst0), .pc(pc0), .instruction(ins0), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_instr(ifi0), .if_id_pc4(ifp0), .if_id_valid(ifv0),
        .halted(hlt0), .fetch_count(cnt0)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .reset(rst1), .pc(pc1), .instruction(ins1), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_instr(ifi1), .if_id_pc4(ifp1), .if_id_valid(ifv1),
        .halted(hlt1), .fetch_count(cnt1)
    );

    typedef struct {
        string       name;
        bit          sel;
        logic [31:0] pc, instr, pc4, cnt;
        bit          valid, halted, ci, cp;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event chk_ev;

    always begin
        @(posedge clk or chk_ev);
        #1;
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] apc, ai, ap4, ac;
            logic        av, ah;
            bit          bad;
            e   = q.pop_front();
            apc = e.sel ? pc1  : pc0;
            ai  = e.sel ? ifi1 : ifi0;
            ap4 = e.sel ? ifp1 : ifp0;
            ac  = e.sel ? cnt1 : cnt0;
            av  = e.sel ? ifv1 : ifv0;
            ah  = e.sel ? hlt1 : hlt0;
            bad = (apc !== e.pc) || (ac !== e.cnt) || (av !== e.valid) ||
                  (ah !== e.halted) || (e.ci && ai !== e.instr) ||
                  (e.cp && ap4 !== e.pc4);
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s: got pc=%h instr=%h pc4=%h valid=%b halted=%b cnt=%0d; want pc=%h instr=%h(chk %b) pc4=%h(chk %b) valid=%b halted=%b cnt=%0d",
                         e.name, apc, ai, ap4, av, ah, ac, e.pc, e.instr, e.ci,
                         e.pc4, e.cp, e.valid, e.halted, e.cnt);
            end
        end
    end

    function automatic exp_t mk(input string nm, input bit sel, input logic [31:0] epc,
                                input logic [31:0] ei, input logic [31:0] ep4,
                                input bit ev, input bit eh, input logic [31:0] ec,
                                input bit ci, input bit cp);
        exp_t e;
        e.name = nm; e.sel = sel; e.pc = epc; e.instr = ei; e.pc4 = ep4;
        e.valid = ev; e.halted = eh; e.cnt = ec; e.ci = ci; e.cp = cp;
        return e;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit st, input bit rv, input logic [31:0] rpc, input exp_t e);
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks the outputs before any edge.
    task automatic do_reset(input bit sel, input string nm, input logic [31:0] rpc_val);
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #2;
        if (sel) rst1 = 1'b1; else rst0 = 1'b1;
        #1;
        q.push_back(mk(nm, sel, rpc_val, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1));
        ->chk_ev;
        @(negedge clk);
        if (sel) rst1 = 1'b0; else rst0 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        do_reset(0, "reset_state", 32'h0);
        step(0, 0, 0, mk("line_A", 0, 32'h04, 32'h1111_1111, 32'h04, 1, 0, 1, 1, 1));
        step(0, 0, 0, mk("line_B", 0, 32'h08, 32'h2222_2222, 32'h08, 1, 0, 2, 1, 1));
        step(0, 0, 0, mk("line_C", 0, 32'h0C, 32'h3333_3333, 32'h0C, 1, 0, 3, 1, 1));

        do_reset(0, "reset_mid_run", 32'h0);
        step(0, 0, 0, mk("rerun_A", 0, 32'h04, 32'h1111_1111, 32'h04, 1, 0, 1, 1, 1));
        step(0, 0, 0, mk("rerun_B", 0, 32'h08, 32'h2222_2222, 32'h08, 1, 0, 2, 1, 1));
        step(1, 0, 0, mk("stall_1", 0, 32'h08, 32'h2222_2222, 32'h08, 1, 0, 2, 1, 1));
        step(1, 0, 0, mk("stall_2", 0, 32'h08, 32'h2222_2222, 32'h08, 1, 0, 2, 1, 1));
        step(0, 0, 0, mk("stall_rel", 0, 32'h0C, 32'h3333_3333, 32'h0C, 1, 0, 3, 1, 1));
        step(0, 0, 0, mk("adv_D", 0, 32'h10, 32'h4444_4444, 32'h10, 1, 0, 4, 1, 1));

        step(1, 1, 32'h0000_004E, mk("redir_stall", 0, 32'h4C, 32'h0, 32'h0, 0, 0, 4, 1, 0));
        step(0, 0, 0, mk("adv_after_redir", 0, 32'h50, 32'h5555_5555, 32'h50, 1, 0, 5, 1, 1));
        step(0, 1, 32'h10, mk("redir_to_10", 0, 32'h10, 32'h0, 32'h0, 0, 0, 5, 1, 0));
        step(0, 0, 0, mk("fetch_halt", 0, 32'h14, 32'h0000_000C, 32'h14, 1, 0, 6, 1, 1));
        step(0, 1, 32'h10, mk("redir_beats_halt", 0, 32'h10, 32'h0, 32'h0, 0, 0, 6, 1, 0));
        step(0, 0, 0, mk("refetch_halt", 0, 32'h14, 32'h0000_000C, 32'h14, 1, 0, 7, 1, 1));
        step(1, 0, 0, mk("halt_entry_stall", 0, 32'h14, 32'h0, 32'h0, 0, 1, 7, 0, 0));
        for (int i = 0; i < 5; i++)
            step(i[0], 1, 32'h80, mk("halt_frozen", 0, 32'h14, 32'h0, 32'h0, 0, 1, 7, 0, 0));

        do_reset(0, "reset_in_halt", 32'h0);
        step(0, 0, 0, mk("post_halt_adv", 0, 32'h04, 32'h1111_1111, 32'h04, 1, 0, 1, 1, 1));

        do_reset(1, "wrap_reset", 32'hFFFF_FFFC);
        step(0, 0, 0, mk("wrap_adv", 1, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 0, 1, 1, 1));
        step(0, 0, 0, mk("wrap_adv2", 1, 32'h4, 32'h1111_1111, 32'h4, 1, 0, 2, 1, 1));
        do_reset(1, "wrap_async_reset", 32'hFFFF_FFFC);

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
